// File: rtl/xsip_board_rail_monitor_if.sv
// Report bus for the XSIP board rail monitor.
// Purpose : groups the sample request, rail readings, thresholds and the
//           valid/ready report channel into one bundle.
// Modports: master - requester / telemetry packer side (drives requests, ready)
//           slave  - the rail monitor (drives the report and status)
interface xsip_board_rail_monitor_if #(
  parameter int N_RAILS = 16,
  parameter int DATA_W  = 32
);
  localparam int IDX_W = $clog2(N_RAILS);

  logic                        sample_start;
  logic [N_RAILS*DATA_W-1:0]   rail_value;
  logic [DATA_W-1:0]           thr_high;
  logic [DATA_W-1:0]           thr_clear;
  logic                        report_ready;
  logic                        report_valid;
  logic [DATA_W+IDX_W-1:0]     total_power;
  logic [DATA_W-1:0]           max_value;
  logic [IDX_W-1:0]            max_idx;
  logic [N_RAILS*DATA_W-1:0]   avg_out;
  logic [N_RAILS-1:0]          alarm_vec;
  logic                        busy;
  logic [15:0]                 dropped_cnt;

  modport master (
    output sample_start, rail_value, thr_high, thr_clear, report_ready,
    input  report_valid, total_power, max_value, max_idx, avg_out,
           alarm_vec, busy, dropped_cnt
  );

  modport slave (
    input  sample_start, rail_value, thr_high, thr_clear, report_ready,
    output report_valid, total_power, max_value, max_idx, avg_out,
           alarm_vec, busy, dropped_cnt
  );
endinterface

// File: rtl/xsip_board_rail_monitor.sv
// Board power-rail monitor.
// Purpose : on sample_start, snapshot every rail reading, then scan one rail
//           per clock computing the total, the maximum and its index, a
//           per-rail exponential moving average and a debounced per-rail
//           over-limit alarm. The result is offered as one report on a
//           valid/ready handshake.
// Ports   : clk  - system clock
//           rst  - asynchronous active-high reset
//           bus  - xsip_board_rail_monitor_if.slave (request, readings,
//                  thresholds, report outputs, busy, dropped_cnt)
module xsip_board_rail_monitor #(
  parameter int N_RAILS   = 16,
  parameter int DATA_W    = 32,
  parameter int AVG_SHIFT = 3,
  parameter int ALARM_CNT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  xsip_board_rail_monitor_if.slave    bus
);
  localparam int IDX_W = $clog2(N_RAILS);
  localparam int SUM_W = DATA_W + IDX_W;
  localparam logic [3:0] ALARM_LIM = 4'(ALARM_CNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RAILS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t                      state_reg;
  logic [N_RAILS*DATA_W-1:0]   snap_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [SUM_W-1:0]            sum_reg;
  logic [DATA_W-1:0]           max_reg;
  logic [IDX_W-1:0]            max_idx_reg;
  logic                        first_done_reg;

  logic                        report_valid_reg;
  logic [SUM_W-1:0]            total_reg;
  logic [DATA_W-1:0]           max_value_reg;
  logic [IDX_W-1:0]            max_idx_out_reg;
  logic [N_RAILS*DATA_W-1:0]   avg_out_reg;
  logic [N_RAILS-1:0]          alarm_out_reg;
  logic [15:0]                 dropped_reg;

  logic [DATA_W-1:0]           rail_x;
  logic [N_RAILS*DATA_W-1:0]   ema_flat;
  logic [N_RAILS-1:0]          alarm_flat;

  // Reading currently being scanned (feeds the sum and the max tracker).
  assign rail_x = snap_reg[int'(idx_reg)*DATA_W +: DATA_W];

  // Per-rail EMA and alarm debounce. Each rail only updates in the cycle the
  // scan reaches it, so thresholds are effectively sampled rail by rail.
  genvar gi;
  generate
    for (gi = 0; gi < N_RAILS; gi++) begin : g_rail
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] ema_reg;
      logic [3:0]        cnt_reg;
      logic              alarm_reg;
      logic              hit;

      assign x   = snap_reg[gi*DATA_W +: DATA_W];
      assign hit = (state_reg == SCAN) && (idx_reg == IDX_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ema_reg   <= '0;
          cnt_reg   <= '0;
          alarm_reg <= 1'b0;
        end else if (hit) begin
          // The first scan after reset seeds the average with the raw reading.
          if (!first_done_reg)
            ema_reg <= x;
          else
            ema_reg <= ema_reg - (ema_reg >> AVG_SHIFT) + (x >> AVG_SHIFT);

          if (x > bus.thr_high) begin
            if (cnt_reg != ALARM_LIM)
              cnt_reg <= cnt_reg + 4'd1;
            // Raise when this sample brings the count to ALARM_CNT.
            if (cnt_reg >= ALARM_LIM - 4'd1)
              alarm_reg <= 1'b1;
          end else if (x <= bus.thr_clear) begin
            cnt_reg   <= '0;
            alarm_reg <= 1'b0;
          end else begin
            // Hysteresis band: restart the debounce, keep the alarm as is.
            cnt_reg <= '0;
          end
        end
      end

      assign ema_flat[gi*DATA_W +: DATA_W] = ema_reg;
      assign alarm_flat[gi]                = alarm_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      snap_reg         <= '0;
      idx_reg          <= '0;
      sum_reg          <= '0;
      max_reg          <= '0;
      max_idx_reg      <= '0;
      first_done_reg   <= 1'b0;
      report_valid_reg <= 1'b0;
      total_reg        <= '0;
      max_value_reg    <= '0;
      max_idx_out_reg  <= '0;
      avg_out_reg      <= '0;
      alarm_out_reg    <= '0;
      dropped_reg      <= '0;
    end else begin
      if (state_reg != IDLE && bus.sample_start && dropped_reg != 16'hFFFF)
        dropped_reg <= dropped_reg + 16'd1;

      case (state_reg)
        IDLE: begin
          if (bus.sample_start) begin
            snap_reg    <= bus.rail_value;
            sum_reg     <= '0;
            max_reg     <= '0;
            max_idx_reg <= '0;
            idx_reg     <= '0;
            state_reg   <= SCAN;
          end
        end

        SCAN: begin
          sum_reg <= sum_reg + SUM_W'(rail_x);
          // Strict compare keeps the lowest index on ties.
          if (rail_x > max_reg) begin
            max_reg     <= rail_x;
            max_idx_reg <= idx_reg;
          end
          if (idx_reg == LAST_IDX)
            state_reg <= REPORT;
          else
            idx_reg <= idx_reg + 1'b1;
        end

        REPORT: begin
          if (!report_valid_reg) begin
            // First REPORT cycle: the last rail has settled, publish.
            total_reg        <= sum_reg;
            max_value_reg    <= max_reg;
            max_idx_out_reg  <= max_idx_reg;
            avg_out_reg      <= ema_flat;
            alarm_out_reg    <= alarm_flat;
            first_done_reg   <= 1'b1;
            report_valid_reg <= 1'b1;
          end else if (bus.report_ready) begin
            report_valid_reg <= 1'b0;
            state_reg        <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.report_valid = report_valid_reg;
  assign bus.total_power  = total_reg;
  assign bus.max_value    = max_value_reg;
  assign bus.max_idx      = max_idx_out_reg;
  assign bus.avg_out      = avg_out_reg;
  assign bus.alarm_vec    = alarm_out_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.dropped_cnt  = dropped_reg;
endmodule

// File: tb/tb_xsip_board_rail_monitor.sv
// Directed testbench for xsip_board_rail_monitor (16 rails, 32-bit readings,
// AVG_SHIFT=3, ALARM_CNT=4). Expected values are hand-computed constants.
module tb_xsip_board_rail_monitor;
  localparam int N = 16;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xsip_board_rail_monitor_if #(.N_RAILS(N), .DATA_W(W)) bus ();

  xsip_board_rail_monitor #(
    .N_RAILS(N), .DATA_W(W), .AVG_SHIFT(3), .ALARM_CNT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [W-1:0] avg(input int i);
    return bus.avg_out[i*W +: W];
  endfunction

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) bus.rail_value[i*W +: W] = v;
  endtask

  // Pulse sample_start for one cycle and wait (bounded) for report_valid.
  task automatic run_scan(input string tag, output int lat);
    @(negedge clk);
    bus.sample_start = 1'b1;
    @(posedge clk);
    #1 bus.sample_start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.report_valid) break;
    end
    if (!bus.report_valid) check_eq({tag, " timeout"}, 64'd0, 64'd1);
    $display("scan %s: lat=%0d total=%0d max=%0d idx=%0d alarm=%h avg0=%0d",
             tag, lat, bus.total_power, bus.max_value, bus.max_idx,
             bus.alarm_vec, avg(0));
  endtask

  task automatic ack;
    bus.report_ready = 1'b1;
    @(posedge clk);
    #1 bus.report_ready = 1'b0;
  endtask

  int  lat;
  logic stable;

  initial begin
    rst = 1'b1;
    bus.sample_start = 1'b0;
    bus.report_ready = 1'b0;
    bus.thr_high     = '1;
    bus.thr_clear    = '1;
    set_all('0);
    #12;
    check_eq("rst valid", bus.report_valid, 0);
    check_eq("rst busy", bus.busy, 0);
    check_eq("rst total", bus.total_power, 0);
    check_eq("rst dropped", bus.dropped_cnt, 0);
    @(negedge clk) rst = 1'b0;

    // Ramp: rail i = 100*(i+1)
    for (int i = 0; i < N; i++) bus.rail_value[i*W +: W] = 32'(100 * (i + 1));
    run_scan("ramp", lat);
    check_eq("ramp latency", lat, 17);
    check_eq("ramp busy", bus.busy, 1);
    check_eq("ramp total", bus.total_power, 13600);
    check_eq("ramp max", bus.max_value, 1600);
    check_eq("ramp idx", bus.max_idx, 15);
    check_eq("ramp avg0", avg(0), 100);
    check_eq("ramp avg15", avg(15), 1600);
    check_eq("ramp alarm", bus.alarm_vec, 0);
    ack();
    check_eq("ramp ack valid", bus.report_valid, 0);
    check_eq("ramp ack busy", bus.busy, 0);

    // Reset in the middle of a scan (idx=7)
    @(negedge clk);
    bus.sample_start = 1'b1;
    @(posedge clk);
    #1 bus.sample_start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midrst total", bus.total_power, 0);
    check_eq("midrst max", bus.max_value, 0);
    check_eq("midrst avg15", avg(15), 0);
    check_eq("midrst busy", bus.busy, 0);
    check_eq("midrst valid", bus.report_valid, 0);
    $display("reset asserted mid-scan");
    @(negedge clk) rst = 1'b0;

    // First scan after reset seeds EMA, second applies the 1/8 filter
    set_all(32'd50);
    bus.rail_value[0 +: W] = 32'd800;
    run_scan("ema1", lat);
    check_eq("ema1 avg0", avg(0), 800);
    check_eq("ema1 avg1", avg(1), 50);
    ack();
    bus.rail_value[0 +: W] = 32'd0;
    run_scan("ema2", lat);
    check_eq("ema2 avg0", avg(0), 700);
    check_eq("ema2 avg1", avg(1), 50);
    check_eq("ema2 total", bus.total_power, 750);
    check_eq("ema2 max", bus.max_value, 50);
    check_eq("ema2 idx", bus.max_idx, 1);
    ack();

    // Tie on the maximum: lowest index wins
    set_all(32'd10);
    bus.rail_value[3*W +: W] = 32'd5000;
    bus.rail_value[9*W +: W] = 32'd5000;
    run_scan("tie", lat);
    check_eq("tie max", bus.max_value, 5000);
    check_eq("tie idx", bus.max_idx, 3);
    check_eq("tie total", bus.total_power, 10140);
    ack();

    // Alarm debounce and hysteresis on rail 2
    bus.thr_high  = 32'd800;
    bus.thr_clear = 32'd500;
    set_all(32'd10);
    bus.rail_value[2*W +: W] = 32'd900;
    for (int s = 1; s <= 4; s++) begin
      run_scan("alarm_over", lat);
      check_eq($sformatf("alarm over %0d", s), bus.alarm_vec, (s == 4) ? 64'h4 : 64'h0);
      ack();
    end
    bus.rail_value[2*W +: W] = 32'd600;
    for (int s = 1; s <= 2; s++) begin
      run_scan("alarm_hold", lat);
      check_eq($sformatf("alarm hold %0d", s), bus.alarm_vec, 64'h4);
      ack();
    end
    bus.rail_value[2*W +: W] = 32'd400;
    run_scan("alarm_clear", lat);
    check_eq("alarm clear", bus.alarm_vec, 0);
    ack();

    // All-zero rails
    set_all('0);
    run_scan("zero", lat);
    check_eq("zero max", bus.max_value, 0);
    check_eq("zero idx", bus.max_idx, 0);
    check_eq("zero total", bus.total_power, 0);
    ack();

    // Backpressure with dropped requests
    set_all(32'd10);
    run_scan("bp", lat);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.sample_start = (c == 3 || c == 8 || c == 13);
      stable &= bus.report_valid && (bus.total_power == 160) && (bus.max_value == 10);
    end
    @(negedge clk);
    bus.sample_start = 1'b0;
    stable &= bus.report_valid && (bus.total_power == 160);
    check_eq("bp stable", stable, 1);
    check_eq("bp dropped", bus.dropped_cnt, 3);
    #4;
    ack();
    check_eq("bp ack valid", bus.report_valid, 0);
    check_eq("bp ack busy", bus.busy, 0);
    $display("backpressure: dropped=%0d", bus.dropped_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
